// File: rtl/scr1_pipe_sm4_rnd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : scr1_sm4_pkg
// Description : SM4 round-unit types, S-box table, FK/CK constants and the
//               linear transforms L / L'.
// Revision    : 1.0 - initial release
// ============================================================================
package scr1_sm4_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUB  = 2'd1,
        LIN  = 2'd2,
        DONE = 2'd3
    } type_scr1_sm4_fsm_e;

    localparam logic [7:0] SBOX [0:255] = '{
        8'hd6, 8'h90, 8'he9, 8'hfe, 8'hcc, 8'he1, 8'h3d, 8'hb7, 8'h16, 8'hb6, 8'h14, 8'hc2, 8'h28, 8'hfb, 8'h2c, 8'h05,
        8'h2b, 8'h67, 8'h9a, 8'h76, 8'h2a, 8'hbe, 8'h04, 8'hc3, 8'haa, 8'h44, 8'h13, 8'h26, 8'h49, 8'h86, 8'h06, 8'h99,
        8'h9c, 8'h42, 8'h50, 8'hf4, 8'h91, 8'hef, 8'h98, 8'h7a, 8'h33, 8'h54, 8'h0b, 8'h43, 8'hed, 8'hcf, 8'hac, 8'h62,
        8'he4, 8'hb3, 8'h1c, 8'ha9, 8'hc9, 8'h08, 8'he8, 8'h95, 8'h80, 8'hdf, 8'h94, 8'hfa, 8'h75, 8'h8f, 8'h3f, 8'ha6,
        8'h47, 8'h07, 8'ha7, 8'hfc, 8'hf3, 8'h73, 8'h17, 8'hba, 8'h83, 8'h59, 8'h3c, 8'h19, 8'he6, 8'h85, 8'h4f, 8'ha8,
        8'h68, 8'h6b, 8'h81, 8'hb2, 8'h71, 8'h64, 8'hda, 8'h8b, 8'hf8, 8'heb, 8'h0f, 8'h4b, 8'h70, 8'h56, 8'h9d, 8'h35,
        8'h1e, 8'h24, 8'h0e, 8'h5e, 8'h63, 8'h58, 8'hd1, 8'ha2, 8'h25, 8'h22, 8'h7c, 8'h3b, 8'h01, 8'h21, 8'h78, 8'h87,
        8'hd4, 8'h00, 8'h46, 8'h57, 8'h9f, 8'hd3, 8'h27, 8'h52, 8'h4c, 8'h36, 8'h02, 8'he7, 8'ha0, 8'hc4, 8'hc8, 8'h9e,
        8'hea, 8'hbf, 8'h8a, 8'hd2, 8'h40, 8'hc7, 8'h38, 8'hb5, 8'ha3, 8'hf7, 8'hf2, 8'hce, 8'hf9, 8'h61, 8'h15, 8'ha1,
        8'he0, 8'hae, 8'h5d, 8'ha4, 8'h9b, 8'h34, 8'h1a, 8'h55, 8'had, 8'h93, 8'h32, 8'h30, 8'hf5, 8'h8c, 8'hb1, 8'he3,
        8'h1d, 8'hf6, 8'he2, 8'h2e, 8'h82, 8'h66, 8'hca, 8'h60, 8'hc0, 8'h29, 8'h23, 8'hab, 8'h0d, 8'h53, 8'h4e, 8'h6f,
        8'hd5, 8'hdb, 8'h37, 8'h45, 8'hde, 8'hfd, 8'h8e, 8'h2f, 8'h03, 8'hff, 8'h6a, 8'h72, 8'h6d, 8'h6c, 8'h5b, 8'h51,
        8'h8d, 8'h1b, 8'haf, 8'h92, 8'hbb, 8'hdd, 8'hbc, 8'h7f, 8'h11, 8'hd9, 8'h5c, 8'h41, 8'h1f, 8'h10, 8'h5a, 8'hd8,
        8'h0a, 8'hc1, 8'h31, 8'h88, 8'ha5, 8'hcd, 8'h7b, 8'hbd, 8'h2d, 8'h74, 8'hd0, 8'h12, 8'hb8, 8'he5, 8'hb4, 8'hb0,
        8'h89, 8'h69, 8'h97, 8'h4a, 8'h0c, 8'h96, 8'h77, 8'h7e, 8'h65, 8'hb9, 8'hf1, 8'h09, 8'hc5, 8'h6e, 8'hc6, 8'h84,
        8'h18, 8'hf0, 8'h7d, 8'hec, 8'h3a, 8'hdc, 8'h4d, 8'h20, 8'h79, 8'hee, 8'h5f, 8'h3e, 8'hd7, 8'hcb, 8'h39, 8'h48
    };

    // Key-schedule constants; consumed by software, never by the datapath.
    localparam logic [31:0] FK [0:3] = '{
        32'hA3B1BAC6, 32'h56AA3350, 32'h677D9197, 32'hB27022DC
    };

    localparam logic [31:0] CK [0:31] = '{
        32'h00070e15, 32'h1c232a31, 32'h383f464d, 32'h545b6269,
        32'h70777e85, 32'h8c939aa1, 32'ha8afb6bd, 32'hc4cbd2d9,
        32'he0e7eef5, 32'hfc030a11, 32'h181f262d, 32'h343b4249,
        32'h50575e65, 32'h6c737a81, 32'h888f969d, 32'ha4abb2b9,
        32'hc0c7ced5, 32'hdce3eaf1, 32'hf8ff060d, 32'h141b2229,
        32'h30373e45, 32'h4c535a61, 32'h686f767d, 32'h848b9299,
        32'ha0a7aeb5, 32'hbcc3cad1, 32'hd8dfe6ed, 32'hf4fb0209,
        32'h10171e25, 32'h2c333a41, 32'h484f565d, 32'h646b7279
    };

    function automatic logic [31:0] rol32(input logic [31:0] x, input int unsigned n);
        return (x << n) | (x >> (32 - n));
    endfunction

    function automatic logic [31:0] sm4_l(input logic [31:0] b);
        return b ^ rol32(b, 2) ^ rol32(b, 10) ^ rol32(b, 18) ^ rol32(b, 24);
    endfunction

    function automatic logic [31:0] sm4_lkey(input logic [31:0] b);
        return b ^ rol32(b, 13) ^ rol32(b, 23);
    endfunction

endpackage : scr1_sm4_pkg
`default_nettype wire

// File: rtl/scr1_pipe_sm4_rnd_if.sv
`default_nettype none
// ============================================================================
// Module      : scr1_pipe_sm4_rnd_if
// Description : EXU / MPRF <-> SM4 round unit request and write-back bundle.
// Revision    : 1.0 - initial release
// ============================================================================
interface scr1_pipe_sm4_rnd_if;

    logic        exu2sm4_req;
    logic        exu2sm4_op_key;
    logic        exu2sm4_kill;
    logic [31:0] exu2sm4_rk;
    logic [31:0] mprf2sm4_t0_data;
    logic [31:0] mprf2sm4_t1_data;
    logic [31:0] mprf2sm4_t2_data;
    logic [31:0] mprf2sm4_t3_data;
    logic        sm4_busy;
    logic        sm4_ack;
    logic        sm42mprf_w_req;
    logic [31:0] sm42mprf_rd_data;
    logic        sm42mprf_is_sm4_enc;
    logic        sm42mprf_is_sm4_key;

    modport master (
        output exu2sm4_req, exu2sm4_op_key, exu2sm4_kill, exu2sm4_rk,
        output mprf2sm4_t0_data, mprf2sm4_t1_data, mprf2sm4_t2_data, mprf2sm4_t3_data,
        input  sm4_busy, sm4_ack, sm42mprf_w_req, sm42mprf_rd_data,
        input  sm42mprf_is_sm4_enc, sm42mprf_is_sm4_key
    );

    modport slave (
        input  exu2sm4_req, exu2sm4_op_key, exu2sm4_kill, exu2sm4_rk,
        input  mprf2sm4_t0_data, mprf2sm4_t1_data, mprf2sm4_t2_data, mprf2sm4_t3_data,
        output sm4_busy, sm4_ack, sm42mprf_w_req, sm42mprf_rd_data,
        output sm42mprf_is_sm4_enc, sm42mprf_is_sm4_key
    );

endinterface : scr1_pipe_sm4_rnd_if
`default_nettype wire

// File: rtl/scr1_pipe_sm4_rnd_sbox.sv
`default_nettype none
// ============================================================================
// Module      : scr1_sm4_sbox
// Description : Single 8-bit SM4 S-box, optionally output-registered.
// Revision    : 1.0 - initial release
// ============================================================================
module scr1_sm4_sbox
    import scr1_sm4_pkg::*;
#(
    parameter bit SCR1_SM4_SBOX_REG = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] sbox_in_i,
    output logic [7:0] sbox_out_o
);

    logic [7:0] lookup;

    assign lookup = SBOX[sbox_in_i];

    generate
        if (SCR1_SM4_SBOX_REG) begin : g_reg
            logic [7:0] sbox_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    sbox_q <= '0;
                end else begin
                    sbox_q <= lookup;
                end
            end

            assign sbox_out_o = sbox_q;
        end else begin : g_comb
            logic unused_clk_rst;

            assign unused_clk_rst = clk ^ rst;
            assign sbox_out_o     = lookup;
        end
    endgenerate

endmodule : scr1_sm4_sbox
`default_nettype wire

// File: rtl/scr1_pipe_sm4_rnd.sv
`default_nettype none
// ============================================================================
// Module      : scr1_pipe_sm4_rnd
// Description : Multi-cycle SM4 round (enc L / key L') with one shared S-box.
// Revision    : 1.0 - initial release
// ============================================================================
module scr1_pipe_sm4_rnd
    import scr1_sm4_pkg::*;
#(
    parameter bit SCR1_SM4_SBOX_REG = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    scr1_pipe_sm4_rnd_if.slave   sm4_if
);

    type_scr1_sm4_fsm_e state_q, state_d;
    logic [1:0]         cnt_q, cnt_d;
    logic               phase_q, phase_d;
    logic [31:0]        a_q, a_d;
    logic [31:0]        t0_q, t0_d;
    logic [31:0]        res_q, res_d;
    logic               op_key_q, op_key_d;
    logic [7:0]         sbox_in, sbox_out;
    logic               accept;
    logic               byte_wr;
    logic               done;

    assign accept  = (state_q == IDLE) && sm4_if.exu2sm4_req && !sm4_if.exu2sm4_kill && !rst;
    assign sbox_in = a_q[{cnt_q, 3'b000} +: 8];
    // Registered S-box splits each byte into a lookup phase and a writeback phase.
    assign byte_wr = (state_q == SUB) && (!SCR1_SM4_SBOX_REG || phase_q);

    scr1_sm4_sbox #(
        .SCR1_SM4_SBOX_REG (SCR1_SM4_SBOX_REG)
    ) i_sbox (
        .clk        (clk),
        .rst        (rst),
        .sbox_in_i  (sbox_in),
        .sbox_out_o (sbox_out)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        phase_d  = phase_q;
        a_d      = a_q;
        t0_d     = t0_q;
        res_d    = res_q;
        op_key_d = op_key_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    a_d      = sm4_if.mprf2sm4_t1_data ^ sm4_if.mprf2sm4_t2_data
                             ^ sm4_if.mprf2sm4_t3_data ^ sm4_if.exu2sm4_rk;
                    t0_d     = sm4_if.mprf2sm4_t0_data;
                    op_key_d = sm4_if.exu2sm4_op_key;
                    cnt_d    = 2'd0;
                    phase_d  = 1'b0;
                    state_d  = SUB;
                end
            end
            SUB: begin
                if (sm4_if.exu2sm4_kill) begin
                    state_d = IDLE;
                end else begin
                    phase_d = SCR1_SM4_SBOX_REG & ~phase_q;
                    if (byte_wr) begin
                        a_d[{cnt_q, 3'b000} +: 8] = sbox_out;
                        cnt_d = cnt_q + 2'd1;
                        if (cnt_q == 2'd3) begin
                            state_d = LIN;
                        end
                    end
                end
            end
            LIN: begin
                if (sm4_if.exu2sm4_kill) begin
                    state_d = IDLE;
                end else begin
                    res_d   = t0_q ^ (op_key_q ? sm4_lkey(a_q) : sm4_l(a_q));
                    state_d = DONE;
                end
            end
            // A retiring result is never flushed, so kill is ignored here.
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            phase_q  <= 1'b0;
            a_q      <= '0;
            t0_q     <= '0;
            res_q    <= '0;
            op_key_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            phase_q  <= phase_d;
            a_q      <= a_d;
            t0_q     <= t0_d;
            res_q    <= res_d;
            op_key_q <= op_key_d;
        end
    end

    assign done                       = (state_q == DONE);
    assign sm4_if.sm4_busy            = (state_q != IDLE);
    assign sm4_if.sm4_ack             = accept;
    assign sm4_if.sm42mprf_w_req      = done;
    assign sm4_if.sm42mprf_rd_data    = done ? res_q : '0;
    assign sm4_if.sm42mprf_is_sm4_enc = done & ~op_key_q;
    assign sm4_if.sm42mprf_is_sm4_key = done & op_key_q;

endmodule : scr1_pipe_sm4_rnd
`default_nettype wire

// File: tb/tb_scr1_pipe_sm4_rnd.sv
`default_nettype none
// ============================================================================
// Module      : tb_scr1_pipe_sm4_rnd
// Description : Scoreboard bench for the SM4 round unit, both S-box variants.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_scr1_pipe_sm4_rnd;
    import scr1_sm4_pkg::*;

    localparam logic [31:0] X0  = 32'h01234567;
    localparam logic [31:0] X1  = 32'h89ABCDEF;
    localparam logic [31:0] X2  = 32'hFEDCBA98;
    localparam logic [31:0] X3  = 32'h76543210;
    localparam logic [31:0] RK0 = 32'hF12186F9;
    localparam logic [31:0] ENC_RES   = 32'h27FAD345;
    localparam logic [31:0] ENC_RES_Z = 32'h26D99622;   // t0 = 0: result shifts by t0 linearly
    localparam logic [31:0] KEY_RES   = 32'hF12186F9;
    localparam logic [31:0] KEY_RES_Z = 32'h53B37958;

    typedef struct {
        logic [31:0] data;
        logic        key;
        int          at;
    } exp_t;

    logic clk = 1'b0;
    logic rst0, rst1;
    bit   mon_en = 1'b0;
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;
    exp_t q0[$];
    exp_t q1[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    scr1_pipe_sm4_rnd_if bus0();
    scr1_pipe_sm4_rnd_if bus1();

    scr1_pipe_sm4_rnd #(.SCR1_SM4_SBOX_REG(1'b0)) dut0 (.clk(clk), .rst(rst0), .sm4_if(bus0));
    scr1_pipe_sm4_rnd #(.SCR1_SM4_SBOX_REG(1'b1)) dut1 (.clk(clk), .rst(rst1), .sm4_if(bus1));

    always @(negedge clk) begin : mon0
        exp_t e;
        if (mon_en) begin
            if (bus0.sm42mprf_w_req === 1'b1) begin
                if (q0.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL dut0 unexpected_wreq cycle %0d: got w_req=1 data=%h, required no write", cyc, bus0.sm42mprf_rd_data);
                end else begin
                    e = q0.pop_front();
                    checks++;
                    if (cyc !== e.at) begin
                        errors++; $display("FAIL dut0 wreq_cycle: got %0d, required %0d", cyc, e.at);
                    end
                    checks++;
                    if (bus0.sm42mprf_rd_data !== e.data) begin
                        errors++; $display("FAIL dut0 rd_data: got %h, required %h", bus0.sm42mprf_rd_data, e.data);
                    end
                    checks++;
                    if ({bus0.sm42mprf_is_sm4_enc, bus0.sm42mprf_is_sm4_key} !== {~e.key, e.key}) begin
                        errors++; $display("FAIL dut0 qualifiers enc/key: got %b%b, required %b%b",
                            bus0.sm42mprf_is_sm4_enc, bus0.sm42mprf_is_sm4_key, ~e.key, e.key);
                    end
                end
            end else begin
                checks++;
                if ({bus0.sm42mprf_rd_data, bus0.sm42mprf_is_sm4_enc, bus0.sm42mprf_is_sm4_key} !== 34'd0) begin
                    errors++; $display("FAIL dut0 idle_outputs cycle %0d: got data=%h enc=%b key=%b, required all 0",
                        cyc, bus0.sm42mprf_rd_data, bus0.sm42mprf_is_sm4_enc, bus0.sm42mprf_is_sm4_key);
                end
            end
        end
    end

    always @(negedge clk) begin : mon1
        exp_t e;
        if (mon_en) begin
            if (bus1.sm42mprf_w_req === 1'b1) begin
                if (q1.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL dut1 unexpected_wreq cycle %0d: got w_req=1 data=%h, required no write", cyc, bus1.sm42mprf_rd_data);
                end else begin
                    e = q1.pop_front();
                    checks++;
                    if (cyc !== e.at) begin
                        errors++; $display("FAIL dut1 wreq_cycle: got %0d, required %0d", cyc, e.at);
                    end
                    checks++;
                    if (bus1.sm42mprf_rd_data !== e.data) begin
                        errors++; $display("FAIL dut1 rd_data: got %h, required %h", bus1.sm42mprf_rd_data, e.data);
                    end
                    checks++;
                    if ({bus1.sm42mprf_is_sm4_enc, bus1.sm42mprf_is_sm4_key} !== {~e.key, e.key}) begin
                        errors++; $display("FAIL dut1 qualifiers enc/key: got %b%b, required %b%b",
                            bus1.sm42mprf_is_sm4_enc, bus1.sm42mprf_is_sm4_key, ~e.key, e.key);
                    end
                end
            end else begin
                checks++;
                if ({bus1.sm42mprf_rd_data, bus1.sm42mprf_is_sm4_enc, bus1.sm42mprf_is_sm4_key} !== 34'd0) begin
                    errors++; $display("FAIL dut1 idle_outputs cycle %0d: got data=%h, required 0", cyc, bus1.sm42mprf_rd_data);
                end
            end
        end
    end

    task automatic set_op(input bit d, input logic [31:0] t0, t1, t2, t3, rk,
                          input logic key, input logic req);
        if (d) begin
            bus1.mprf2sm4_t0_data = t0; bus1.mprf2sm4_t1_data = t1;
            bus1.mprf2sm4_t2_data = t2; bus1.mprf2sm4_t3_data = t3;
            bus1.exu2sm4_rk = rk; bus1.exu2sm4_op_key = key; bus1.exu2sm4_req = req;
        end else begin
            bus0.mprf2sm4_t0_data = t0; bus0.mprf2sm4_t1_data = t1;
            bus0.mprf2sm4_t2_data = t2; bus0.mprf2sm4_t3_data = t3;
            bus0.exu2sm4_rk = rk; bus0.exu2sm4_op_key = key; bus0.exu2sm4_req = req;
        end
    endtask

    task automatic expect_op(input bit d, input logic [31:0] data, input logic key, input int at);
        exp_t e;
        e.data = data; e.key = key; e.at = at;
        if (d) q1.push_back(e); else q0.push_back(e);
    endtask

    // Returns at the negedge of the ack cycle, or ack_cyc = -1 on timeout.
    task automatic wait_ack(input bit d, output int ack_cyc);
        ack_cyc = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if ((d ? bus1.sm4_ack : bus0.sm4_ack) === 1'b1) begin
                ack_cyc = cyc;
                break;
            end
            @(posedge clk); #1;
        end
        checks++;
        if (ack_cyc < 0) begin
            errors++; $display("FAIL dut%0d ack_timeout: got no ack in 20 cycles, required ack", d);
        end
    endtask

    task automatic issue(input bit d, input logic [31:0] t0, t1, t2, t3, rk, input logic key,
                         input logic [31:0] exp_data, input bit push, output int ack_cyc);
        @(posedge clk); #1;
        set_op(d, t0, t1, t2, t3, rk, key, 1'b1);
        wait_ack(d, ack_cyc);
        if (push && ack_cyc >= 0) expect_op(d, exp_data, key, ack_cyc + (d ? 10 : 6));
        @(posedge clk); #1;
        if (d) bus1.exu2sm4_req = 1'b0; else bus0.exu2sm4_req = 1'b0;
    endtask

    task automatic drain(input bit d);
        int n = 0;
        while (((d ? q1.size() : q0.size()) != 0) && n < 40) begin
            @(negedge clk); n++;
        end
        checks++;
        if ((d ? q1.size() : q0.size()) != 0) begin
            errors++;
            $display("FAIL dut%0d drain_timeout: got %0d pending results, required 0", d, d ? q1.size() : q0.size());
            if (d) q1.delete(); else q0.delete();
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst0 = 1'b1; rst1 = 1'b1;
        bus0.exu2sm4_kill = 1'b0; bus1.exu2sm4_kill = 1'b0;
        set_op(1'b0, '0, '0, '0, '0, '0, 1'b0, 1'b0);
        set_op(1'b1, '0, '0, '0, '0, '0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({bus0.sm4_busy, bus0.sm4_ack, bus0.sm42mprf_w_req, bus0.sm42mprf_is_sm4_enc,
             bus0.sm42mprf_is_sm4_key, bus0.sm42mprf_rd_data} !== 37'd0) begin
            errors++; $display("FAIL dut0 reset_outputs: got busy=%b ack=%b wreq=%b data=%h, required all 0",
                bus0.sm4_busy, bus0.sm4_ack, bus0.sm42mprf_w_req, bus0.sm42mprf_rd_data);
        end
        checks++;
        if ({bus1.sm4_busy, bus1.sm4_ack, bus1.sm42mprf_w_req, bus1.sm42mprf_is_sm4_enc,
             bus1.sm42mprf_is_sm4_key, bus1.sm42mprf_rd_data} !== 37'd0) begin
            errors++; $display("FAIL dut1 reset_outputs: got busy=%b ack=%b wreq=%b data=%h, required all 0",
                bus1.sm4_busy, bus1.sm4_ack, bus1.sm42mprf_w_req, bus1.sm42mprf_rd_data);
        end
        @(posedge clk); #1;
        rst0 = 1'b0; rst1 = 1'b0;
        @(negedge clk);
        checks++;
        if (bus0.sm4_busy !== 1'b0) begin
            errors++; $display("FAIL dut0 idle_busy_after_reset: got %b, required 0", bus0.sm4_busy);
        end
        mon_en = 1'b1;
    endtask

    task automatic test_enc();
        int a;
        issue(1'b0, X0, X1, X2, X3, RK0, 1'b0, ENC_RES, 1'b1, a);
        @(negedge clk);
        checks++;
        if (bus0.sm4_busy !== 1'b1) begin
            errors++; $display("FAIL dut0 busy_in_sub: got %b, required 1", bus0.sm4_busy);
        end
        drain(1'b0);
        issue(1'b0, 32'h0, X1, X2, X3, RK0, 1'b0, ENC_RES_Z, 1'b1, a);
        drain(1'b0);
        issue(1'b0, X0, X3, X1, X2, RK0, 1'b0, ENC_RES, 1'b1, a);
        drain(1'b0);
    endtask

    task automatic test_key();
        int a;
        issue(1'b0, 32'h01234567 ^ FK[0], 32'h89ABCDEF ^ FK[1], 32'hFEDCBA98 ^ FK[2],
              32'h76543210 ^ FK[3], CK[0], 1'b1, KEY_RES, 1'b1, a);
        drain(1'b0);
        issue(1'b0, 32'h0, 32'hDF01FEBF, 32'h99A12B0F, 32'hC42410CC, 32'h00070E15, 1'b1, KEY_RES_Z, 1'b1, a);
        drain(1'b0);
    endtask

    task automatic test_operand_stability();
        int a;
        issue(1'b0, X0, X1, X2, X3, RK0, 1'b0, ENC_RES, 1'b1, a);
        set_op(1'b0, '1, '1, '1, '1, '1, 1'b1, 1'b0);
        drain(1'b0);
    endtask

    task automatic test_kill();
        int a;
        bus0.exu2sm4_kill = 1'b1;
        set_op(1'b0, X0, X1, X2, X3, RK0, 1'b0, 1'b1);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            checks++;
            if ({bus0.sm4_ack, bus0.sm4_busy} !== 2'b00) begin
                errors++; $display("FAIL dut0 req_with_kill ack/busy: got %b%b, required 00", bus0.sm4_ack, bus0.sm4_busy);
            end
            @(posedge clk); #1;
        end
        bus0.exu2sm4_kill = 1'b0; bus0.exu2sm4_req = 1'b0;
        issue(1'b0, X0, X1, X2, X3, RK0, 1'b0, ENC_RES, 1'b0, a);
        @(posedge clk); #1;
        @(posedge clk); #1;
        bus0.exu2sm4_kill = 1'b1;
        @(posedge clk); #1;
        bus0.exu2sm4_kill = 1'b0;
        @(negedge clk);
        checks++;
        if (bus0.sm4_busy !== 1'b0) begin
            errors++; $display("FAIL dut0 busy_after_kill: got %b, required 0", bus0.sm4_busy);
        end
        repeat (10) @(posedge clk);
        issue(1'b0, X0, X1, X2, X3, RK0, 1'b0, ENC_RES, 1'b1, a);
        drain(1'b0);
        issue(1'b0, X0, X1, X2, X3, RK0, 1'b0, ENC_RES, 1'b1, a);
        repeat (5) @(posedge clk);
        #1;
        bus0.exu2sm4_kill = 1'b1;
        @(posedge clk); #1;
        bus0.exu2sm4_kill = 1'b0;
        drain(1'b0);
    endtask

    task automatic test_reset_mid();
        int a;
        issue(1'b0, X0, X1, X2, X3, RK0, 1'b0, ENC_RES, 1'b0, a);
        @(posedge clk); #1;
        rst0 = 1'b1;
        @(posedge clk); #1;
        rst0 = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus0.sm4_busy, bus0.sm4_ack, bus0.sm42mprf_w_req, bus0.sm42mprf_rd_data} !== 35'd0) begin
            errors++; $display("FAIL dut0 reset_mid_outputs: got busy=%b ack=%b wreq=%b data=%h, required all 0",
                bus0.sm4_busy, bus0.sm4_ack, bus0.sm42mprf_w_req, bus0.sm42mprf_rd_data);
        end
        repeat (10) @(posedge clk);
        #1;
    endtask

    task automatic test_req_while_busy();
        int a;
        issue(1'b0, X0, X1, X2, X3, RK0, 1'b0, ENC_RES, 1'b1, a);
        set_op(1'b0, 32'hA292FFA1, 32'hDF01FEBF, 32'h99A12B0F, 32'hC42410CC, 32'h00070E15, 1'b1, 1'b1);
        for (int k = 1; k <= 6; k++) begin
            if (k > 1) begin
                @(posedge clk); #1;
            end
            @(negedge clk);
            checks++;
            if (bus0.sm4_ack !== 1'b0) begin
                errors++; $display("FAIL dut0 ack_while_busy at N+%0d: got %b, required 0", k, bus0.sm4_ack);
            end
        end
        @(posedge clk); #1;
        bus0.exu2sm4_req = 1'b0;
        drain(1'b0);
    endtask

    task automatic test_sbox_reg();
        int a;
        issue(1'b1, X0, X1, X2, X3, RK0, 1'b0, ENC_RES, 1'b1, a);
        drain(1'b1);
    endtask

    task automatic test_back_to_back();
        int a1, a2;
        @(posedge clk); #1;
        set_op(1'b1, X0, X1, X2, X3, RK0, 1'b0, 1'b1);
        wait_ack(1'b1, a1);
        if (a1 >= 0) expect_op(1'b1, ENC_RES, 1'b0, a1 + 10);
        @(posedge clk); #1;
        set_op(1'b1, 32'hA292FFA1, 32'hDF01FEBF, 32'h99A12B0F, 32'hC42410CC, 32'h00070E15, 1'b1, 1'b1);
        wait_ack(1'b1, a2);
        if (a2 >= 0) expect_op(1'b1, KEY_RES, 1'b1, a2 + 10);
        checks++;
        if (a2 !== a1 + 11) begin
            errors++; $display("FAIL dut1 back_to_back_ack_cycle: got %0d, required %0d", a2, a1 + 11);
        end
        @(posedge clk); #1;
        bus1.exu2sm4_req = 1'b0;
        drain(1'b1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_enc();
        test_key();
        test_operand_stability();
        test_kill();
        test_reset_mid();
        test_req_while_busy();
        test_sbox_reg();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_scr1_pipe_sm4_rnd
`default_nettype wire
